// File: rtl/uart_word_rx.sv
// 8N1 UART receiver that assembles a header byte plus four payload bytes into a 32-bit word.
// Define UART_RX_TIMEOUT_EN to enable the inter-byte timeout of TIMEOUT_BITS bit periods.
module uart_word_rx #(
    parameter int unsigned c_CLKS_PER_BIT = 434,
    parameter int unsigned TIMEOUT_BITS   = 20
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RX,
    output logic [31:0] data_rx,
    output logic        done_rx,
    output logic [1:0]  controlBits,
    output logic        frame_err
);

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned FULL_M1 = c_CLKS_PER_BIT - 1;
    localparam int unsigned HALF_M1 = c_CLKS_PER_BIT / 2 - 1;
    localparam logic [5:0]  HDR_TAG = 6'b101010;

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
    typedef enum logic [2:0] {F_HDR, F_B0, F_B1, F_B2, F_B3} frm_state_t;

    logic             rx_meta, rx_sync, rx_prev, armed;
    logic             fall_c;

    bit_state_t       bit_q, bit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_ok_c, stop_err_c;

    frm_state_t       frm_q, frm_d;
    logic [1:0]       ctrl_pend_q, ctrl_pend_d;
    logic [23:0]      acc_q, acc_d;
    logic [31:0]      data_d;
    logic [1:0]       ctrl_d;
    logic             done_d, err_d;

    // Synchronizer; armed blocks the stale 1->0 seen when the line is already low at reset release.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
            armed   <= 1'b0;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            if (rx_meta) armed <= 1'b1;
        end
    end

    assign fall_c = armed & rx_prev & ~rx_sync;

`ifdef UART_RX_TIMEOUT_EN
    localparam int unsigned TO_LIMIT_M1 = TIMEOUT_BITS * c_CLKS_PER_BIT - 1;
    logic [31:0] to_cnt_q;
    logic        to_run_c, to_hit_c;

    // Idle cycles between bytes of a partially received frame.
    assign to_run_c = (frm_q != F_HDR) && (bit_q == B_IDLE) && !fall_c;
    assign to_hit_c = to_run_c && (to_cnt_q == TO_LIMIT_M1);

    always_ff @(posedge CLK) begin
        if (RST || !to_run_c || to_hit_c) to_cnt_q <= '0;
        else                              to_cnt_q <= to_cnt_q + 32'd1;
    end
`else
    localparam int unsigned timeout_bits_unused = TIMEOUT_BITS;
`endif

    // Bit-level FSM: start qualification, mid-bit sampling, stop check.
    always_comb begin
        bit_d      = bit_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        byte_ok_c  = 1'b0;
        stop_err_c = 1'b0;
        case (bit_q)
            B_IDLE: begin
                if (fall_c) begin
                    bit_d = B_START;
                    cnt_d = '0;
                end
            end
            B_START: begin
                if (cnt_q == CNT_W'(HALF_M1)) begin
                    cnt_d = '0;
                    idx_d = '0;
                    bit_d = rx_sync ? B_IDLE : B_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            B_DATA: begin
                if (cnt_q == CNT_W'(FULL_M1)) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) bit_d = B_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            B_STOP: begin
                if (cnt_q == CNT_W'(FULL_M1)) begin
                    cnt_d = '0;
                    bit_d = B_IDLE;
                    if (rx_sync) byte_ok_c  = 1'b1;
                    else         stop_err_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: bit_d = B_IDLE;
        endcase
    end

    // Frame-level FSM: header check, payload assembly, output update.
    always_comb begin
        frm_d       = frm_q;
        ctrl_pend_d = ctrl_pend_q;
        acc_d       = acc_q;
        data_d      = data_rx;
        ctrl_d      = controlBits;
        done_d      = 1'b0;
        err_d       = 1'b0;
        if (stop_err_c) begin
            err_d = 1'b1;
            frm_d = F_HDR;
        end else if (byte_ok_c) begin
            case (frm_q)
                F_HDR: begin
                    if (shift_q[7:2] == HDR_TAG) begin
                        ctrl_pend_d = shift_q[1:0];
                        frm_d       = F_B0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                F_B0: begin acc_d[7:0]   = shift_q; frm_d = F_B1; end
                F_B1: begin acc_d[15:8]  = shift_q; frm_d = F_B2; end
                F_B2: begin acc_d[23:16] = shift_q; frm_d = F_B3; end
                F_B3: begin
                    data_d = {shift_q, acc_q};
                    ctrl_d = ctrl_pend_q;
                    done_d = 1'b1;
                    frm_d  = F_HDR;
                end
                default: frm_d = F_HDR;
            endcase
        end
`ifdef UART_RX_TIMEOUT_EN
        else if (to_hit_c) begin
            err_d = 1'b1;
            frm_d = F_HDR;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_q       <= B_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            frm_q       <= F_HDR;
            ctrl_pend_q <= '0;
            acc_q       <= '0;
            data_rx     <= '0;
            controlBits <= '0;
            done_rx     <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frm_q       <= frm_d;
            ctrl_pend_q <= ctrl_pend_d;
            acc_q       <= acc_d;
            data_rx     <= data_d;
            controlBits <= ctrl_d;
            done_rx     <= done_d;
            frame_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench for uart_word_rx at 16 clocks per bit; timeout scenario compiled when UART_RX_TIMEOUT_EN is defined.
module tb_uart_word_rx;

    localparam int unsigned C = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        RX  = 1'b1;
    logic [31:0] data_rx;
    logic        done_rx;
    logic [1:0]  controlBits;
    logic        frame_err;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, hold_viol = 0;
    int d0, e0, n;
    logic [31:0] last_data = '0;
    logic [1:0]  last_ctrl = '0;
    logic [31:0] prev_data = '0;
    logic [1:0]  prev_ctrl = '0;

    uart_word_rx #(.c_CLKS_PER_BIT(C), .TIMEOUT_BITS(20)) dut (
        .CLK(CLK), .RST(RST), .RX(RX),
        .data_rx(data_rx), .done_rx(done_rx),
        .controlBits(controlBits), .frame_err(frame_err)
    );

    always #5 CLK = ~CLK;

    // Pulse counters and output-hold monitor, sampled away from the rising edge.
    always @(negedge CLK) begin
        if (done_rx) begin
            done_cnt  <= done_cnt + 1;
            last_data <= data_rx;
            last_ctrl <= controlBits;
        end
        if (frame_err)             err_cnt  <= err_cnt + 1;
        if (done_rx && frame_err)  both_cnt <= both_cnt + 1;
        if (!RST && !done_rx && (data_rx !== prev_data || controlBits !== prev_ctrl))
            hold_viol <= hold_viol + 1;
        prev_data <= data_rx;
        prev_ctrl <= controlBits;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int cycles);
        RX = 1'b1;
        repeat (cycles) @(negedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        RX = 1'b0;
        repeat (C) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (C) @(negedge CLK);
        end
        RX = stop;
        repeat (C) @(negedge CLK);
        RX = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] h, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        send_byte(h, 1'b1);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
        send_byte(b3, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        RST = 1'b1; RX = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_data", data_rx, 32'h0);
        check("rst_ctrl", 32'(controlBits), 32'h0);
        check("rst_done", 32'(done_rx), 32'h0);
        check("rst_err",  32'(frame_err), 32'h0);
        RST = 1'b0;
        idle(2 * C);

        // Good frame
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'hA9, 8'h78, 8'h56, 8'h34, 8'h12);
        idle(4);
        check("good_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("good_err_cnt",  32'(err_cnt - e0), 32'd0);
        check("good_data",     last_data, 32'h12345678);
        check("good_ctrl",     32'(last_ctrl), 32'h1);
        check("good_hold",     data_rx, 32'h12345678);

        // Bad header, then a good frame with control 00
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'h55, 1'b1);
        idle(4);
        check("badhdr_err_cnt",  32'(err_cnt - e0), 32'd1);
        check("badhdr_done_cnt", 32'(done_cnt - d0), 32'd0);
        check("badhdr_hold",     data_rx, 32'h12345678);
        send_frame(8'hA8, 8'hEF, 8'hBE, 8'hAD, 8'hDE);
        idle(4);
        check("badhdr2_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("badhdr2_err_cnt",  32'(err_cnt - e0), 32'd1);
        check("badhdr2_data",     last_data, 32'hDEADBEEF);
        check("badhdr2_ctrl",     32'(last_ctrl), 32'h0);

        // Bad stop bit on the third byte, then recovery
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'hA9, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        idle(2 * C);
        check("badstop_err_cnt",  32'(err_cnt - e0), 32'd1);
        check("badstop_done_cnt", 32'(done_cnt - d0), 32'd0);
        check("badstop_hold",     data_rx, 32'hDEADBEEF);
        send_frame(8'hA9, 8'h44, 8'h33, 8'h22, 8'h11);
        idle(4);
        check("badstop2_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("badstop2_data",     last_data, 32'h11223344);
        check("badstop2_ctrl",     32'(last_ctrl), 32'h1);

        // Glitch of 4 cycles is rejected as a spurious start
        d0 = done_cnt; e0 = err_cnt;
        RX = 1'b0;
        repeat (4) @(negedge CLK);
        idle(3 * C);
        check("glitch_err_cnt",  32'(err_cnt - e0), 32'd0);
        check("glitch_done_cnt", 32'(done_cnt - d0), 32'd0);
        check("glitch_bit_idle", 32'(dut.bit_q), 32'd0);

        // Reset mid-frame discards everything
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'hA9, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        RX = 1'b0;
        repeat (20) @(negedge CLK);
        RST = 1'b1; RX = 1'b1;
        repeat (4) @(negedge CLK);
        RST = 1'b0;
        idle(2 * C);
        check("rstmid_err_cnt",  32'(err_cnt - e0), 32'd0);
        check("rstmid_done_cnt", 32'(done_cnt - d0), 32'd0);
        check("rstmid_data",     data_rx, 32'h0);
        send_frame(8'hAA, 8'h01, 8'h00, 8'h00, 8'h00);
        idle(4);
        check("rstmid2_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("rstmid2_data",     last_data, 32'h00000001);
        check("rstmid2_ctrl",     32'(last_ctrl), 32'h2);

        // Break: one error per failed stop bit, then recovery
        d0 = done_cnt; e0 = err_cnt;
        RX = 1'b0;
        repeat (15 * C) @(negedge CLK);
        idle(2 * C);
        check("break_err_cnt",  32'(err_cnt - e0), 32'd1);
        check("break_done_cnt", 32'(done_cnt - d0), 32'd0);
        send_frame(8'hA8, 8'h78, 8'h56, 8'h34, 8'h12);
        idle(4);
        check("break2_data", last_data, 32'h12345678);
        check("break2_ctrl", 32'(last_ctrl), 32'h0);

        // Back-to-back frames with no idle gap
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'hA9, 8'hDD, 8'hCC, 8'hBB, 8'hAA);
        send_frame(8'hAB, 8'h44, 8'h33, 8'h22, 8'h11);
        idle(4);
        check("b2b_done_cnt", 32'(done_cnt - d0), 32'd2);
        check("b2b_err_cnt",  32'(err_cnt - e0), 32'd0);
        check("b2b_data",     last_data, 32'h11223344);
        check("b2b_ctrl",     32'(last_ctrl), 32'h3);

        // Inter-byte gap of 400 cycles after header plus one byte
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'hA9, 1'b1);
        send_byte(8'h01, 1'b1);
`ifdef UART_RX_TIMEOUT_EN
        n = 0;
        while (err_cnt == e0 && n < 400) begin
            @(negedge CLK); #1;
            n++;
        end
        check("to_err_cnt", 32'(err_cnt - e0), 32'd1);
        check("to_window",  32'((n >= 300) && (n <= 330)), 32'd1);
        idle(C);
        send_frame(8'hA9, 8'h78, 8'h56, 8'h34, 8'h12);
        idle(4);
        check("to_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("to_data",     last_data, 32'h12345678);
`else
        idle(400);
        check("gap_err_cnt", 32'(err_cnt - e0), 32'd0);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        idle(4);
        check("gap_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("gap_data",     last_data, 32'h04030201);
        check("gap_ctrl",     32'(last_ctrl), 32'h1);
`endif

        check("never_both",   32'(both_cnt), 32'd0);
        check("output_hold",  32'(hold_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
